cmd_collector: RTL and testbench
================================

CMD_COLLECTOR -- requirements
Module: cmd_collector

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, inter-byte timeout in clk cycles (1 ms at 50 MHz).
REQ-002 Parameter SKIP_CRLF, default 1, when 1 the block discards 8'h0D/8'h0A received while idle.
REQ-003 clk  input  1  system clock, rising-edge active.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 rx_valid  input  1  one-cycle strobe from the UART receiver: rx_byte is valid.
REQ-006 rx_byte  input  8  received byte.
REQ-007 cmd_ready  output  1  one-cycle pulse: a complete frame is on cmd/addr/data.
REQ-008 cmd  output  8  command byte of the frame.
REQ-009 addr  output  8  address byte of the frame.
REQ-010 data  output  8  data byte of the frame; 8'h00 for read frames.
REQ-011 frame_err  output  1  one-cycle pulse: partial frame abandoned on timeout.
REQ-012 busy  output  1  high while a frame is partially collected.

Function
REQ-013 FSM states: IDLE, GOT_CMD, GOT_ADDR; busy SHALL be high exactly in GOT_CMD and GOT_ADDR.
REQ-014 IDLE + rx_valid: when SKIP_CRLF=1 and the byte is 8'h0D or 8'h0A, drop it and stay in IDLE; otherwise latch it into cmd and go to GOT_CMD.
REQ-015 GOT_CMD + rx_valid: latch addr; if cmd == CMD_READ (8'h52), load data=8'h00, pulse cmd_ready and go to IDLE; otherwise go to GOT_ADDR.
REQ-016 GOT_ADDR + rx_valid: latch data, pulse cmd_ready and go to IDLE.
REQ-017 Any cmd other than 8'h52, including CMD_WRITE (8'h57) and unknown codes, SHALL be collected as a 3-byte frame; the downstream decoder rejects unknown codes.
REQ-018 Address and data values are not checked; range errors belong to the downstream decoder.
REQ-019 cmd_ready is registered: it is high on the cycle after the clock edge that samples the final rx_valid, for exactly one cycle.
REQ-020 cmd/addr/data change only when a byte is latched; they hold their values while cmd_ready is high and afterwards, until the next frame overwrites them.
REQ-021 Timeout counter: cleared on every accepted byte and held at 0 in IDLE; increments each cycle in GOT_CMD/GOT_ADDR without rx_valid.
REQ-022 When the counter reaches TIMEOUT_CYCLES-1 in a busy state: pulse frame_err for one cycle, go to IDLE, no cmd_ready.
REQ-023 If rx_valid and the timeout condition coincide, the byte wins: it is accepted, the counter clears and frame_err does not pulse.
REQ-024 A byte arriving the cycle after a timeout SHALL be treated as a new cmd byte (IDLE rules apply).
REQ-025 In GOT_CMD/GOT_ADDR, CR/LF bytes are ordinary frame bytes, never skipped.
REQ-026 cmd_ready and frame_err SHALL never be high in the same cycle.
REQ-027 Counter width: $clog2(TIMEOUT_CYCLES) bits, minimum 1; the counter must not wrap before the timeout fires.

Reset
REQ-028 On rst low, asynchronously: state=IDLE; counter=0; cmd=addr=data=8'h00; cmd_ready=frame_err=busy=0.
REQ-029 Reset asserted mid-frame discards the partial frame with no cmd_ready or frame_err pulse; the first byte after release is a cmd byte.

Structure
REQ-030 CMD_WRITE, CMD_READ, ASCII_CR and ASCII_LF constants and the collector state encoding SHALL live in the shared package uart_regfile_pkg, which the decoder also uses.
REQ-031 The block is a single module with no sub-modules; the FSM and timeout counter are inline.

Verification
REQ-032 Bytes 57,03,B3 each 10 cycles apart -> one cmd_ready pulse one cycle after the B3 strobe with cmd=57, addr=03, data=B3; busy low afterwards.
REQ-033 Bytes 52,05 -> cmd_ready one cycle after the 05 strobe with cmd=52, addr=05, data=00; next byte 0D in IDLE -> no state change.
REQ-034 TIMEOUT_CYCLES=16; send 57,03 then idle -> frame_err pulses 15 cycles after the last 03 strobe, no cmd_ready; then 52,01 -> normal read frame.
REQ-035 TIMEOUT_CYCLES=16; send 57,03, then 04 on exactly the timeout cycle -> no frame_err; the 04 is accepted as data and cmd_ready fires with data=04.
REQ-036 Bytes 99,02,11 -> cmd_ready with cmd=99, addr=02, data=11 (3-byte unknown frame).
REQ-037 Send 57,03, pull rst low for 2 cycles, then 52,07 -> no pulse during reset; one read frame with addr=07, data=00.

Source files
------------

// File: rtl/uart_regfile_pkg.sv
// Shared definitions for the UART register-file path: byte constants,
// command-collector state encoding and the collected frame payload.
package uart_regfile_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t CMD_WRITE = 8'h57;
  localparam byte_t CMD_READ  = 8'h52;
  localparam byte_t ASCII_CR  = 8'h0D;
  localparam byte_t ASCII_LF  = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_CMD  = 2'd1,
    ST_GOT_ADDR = 2'd2
  } coll_state_e;

  typedef struct packed {
    byte_t cmd;
    byte_t addr;
    byte_t data;
  } cmd_frame_t;

  function automatic logic is_crlf(input byte_t b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/cmd_collector_if.sv
// Byte-stream in / frame out bundle of the command collector.
//   rx_valid, rx_byte          : strobe + byte from the UART receiver
//   cmd_ready, cmd, addr, data : completed-frame pulse and payload
//   frame_err                  : partial frame abandoned on timeout
//   busy                       : a frame is partially collected
interface cmd_collector_if;
  import uart_regfile_pkg::*;

  logic  rx_valid;
  byte_t rx_byte;
  logic  cmd_ready;
  byte_t cmd;
  byte_t addr;
  byte_t data;
  logic  frame_err;
  logic  busy;

  modport slave (
    input  rx_valid, rx_byte,
    output cmd_ready, cmd, addr, data, frame_err, busy
  );

  modport master (
    output rx_valid, rx_byte,
    input  cmd_ready, cmd, addr, data, frame_err, busy
  );

endinterface

// File: rtl/cmd_collector.sv
// Collects UART bytes into cmd/addr[/data] frames. Reads (8'h52) are two
// bytes and report data=8'h00; every other command is three bytes. A
// partial frame is abandoned with frame_err after an inter-byte timeout.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : cmd_collector_if slave (byte stream in, frame out)
module cmd_collector
  import uart_regfile_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter bit          SKIP_CRLF      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  cmd_collector_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Timeout fires on the edge where the idle count would reach TIMEOUT_CYCLES-1,
  // i.e. TIMEOUT_CYCLES-1 idle edges after the last accepted byte.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  coll_state_e      state_q, state_d;
  cmd_frame_t       frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q;
  logic             skip_c;
  logic             timeout_c;

  assign skip_c    = SKIP_CRLF && is_crlf(bus.rx_byte);
  // A byte arriving on the timeout edge takes priority over the timeout.
  assign timeout_c = (state_q != ST_IDLE) && !bus.rx_valid && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid && !skip_c) state_d = ST_GOT_CMD;
      end
      ST_GOT_CMD: begin
        if (bus.rx_valid)   state_d = (frame_q.cmd == CMD_READ) ? ST_IDLE : ST_GOT_ADDR;
        else if (timeout_c) state_d = ST_IDLE;
      end
      ST_GOT_ADDR: begin
        if (bus.rx_valid || timeout_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    frame_d     = frame_q;
    cnt_d       = cnt_q;
    cmd_ready_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.rx_valid && !skip_c) frame_d.cmd = bus.rx_byte;
      end
      ST_GOT_CMD: begin
        if (bus.rx_valid) begin
          cnt_d        = '0;
          frame_d.addr = bus.rx_byte;
          if (frame_q.cmd == CMD_READ) begin
            frame_d.data = 8'h00;
            cmd_ready_d  = 1'b1;
          end
        end else if (timeout_c) begin
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GOT_ADDR: begin
        if (bus.rx_valid) begin
          cnt_d        = '0;
          frame_d.data = bus.rx_byte;
          cmd_ready_d  = 1'b1;
        end else if (timeout_c) begin
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q     <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;
  assign bus.cmd       = frame_q.cmd;
  assign bus.addr      = frame_q.addr;
  assign bus.data      = frame_q.data;

endmodule

// File: tb/tb_cmd_collector.sv
// Directed bench for cmd_collector with a frame/error scoreboard.
module tb_cmd_collector;
  import uart_regfile_pkg::*;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  typedef struct packed {
    logic  err;
    byte_t cmd;
    byte_t addr;
    byte_t data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  cmd_collector_if bus ();

  cmd_collector #(.TIMEOUT_CYCLES(TO), .SKIP_CRLF(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle strobe; returns just after the sampling edge.
  task automatic send_byte(input byte_t b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input byte_t c, input byte_t a, input byte_t d);
    exp_t e;
    e.err = 1'b0; e.cmd = c; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e = '0;
    e.err = 1'b1;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (bus.cmd_ready === 1'b1 || bus.frame_err === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_pulse: got ready=%0b err=%0b expected none",
               bus.cmd_ready, bus.frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.err) begin
          assert (bus.frame_err === 1'b1 && bus.cmd_ready === 1'b0) else begin
            errors++;
            $error("FAIL sb_err: got ready=%0b err=%0b expected ready=0 err=1",
                   bus.cmd_ready, bus.frame_err);
          end
        end else begin
          assert ({bus.cmd_ready, bus.frame_err, bus.cmd, bus.addr, bus.data} ===
                  {2'b10, mon_e.cmd, mon_e.addr, mon_e.data}) else begin
            errors++;
            $error("FAIL sb_frame: got r=%0b e=%0b %0h/%0h/%0h expected r=1 e=0 %0h/%0h/%0h",
                   bus.cmd_ready, bus.frame_err, bus.cmd, bus.addr, bus.data,
                   mon_e.cmd, mon_e.addr, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    wait_cycles(3);
    check("reset_outs", {bus.cmd_ready, bus.frame_err, bus.busy}, 3'b000);
    check("reset_frame", {bus.cmd, bus.addr, bus.data}, 24'h000000);
    rst = 1'b1;
    wait_cycles(2);

    // Write frame, bytes 10 cycles apart
    send_byte(8'h57);
    check("wr_busy_cmd", bus.busy, 1'b1);
    check("wr_cmd_latched", bus.cmd, 8'h57);
    wait_cycles(9);
    send_byte(8'h03);
    check("wr_no_early_ready", bus.cmd_ready, 1'b0);
    wait_cycles(9);
    push_frame(8'h57, 8'h03, 8'hB3);
    send_byte(8'hB3);
    check("wr_ready", bus.cmd_ready, 1'b1);
    check("wr_frame", {bus.cmd, bus.addr, bus.data}, 24'h5703B3);
    check("wr_busy_low", bus.busy, 1'b0);
    wait_cycles(1);
    check("wr_ready_one_cycle", bus.cmd_ready, 1'b0);
    check("wr_frame_held", {bus.cmd, bus.addr, bus.data}, 24'h5703B3);

    // Read frame then CR/LF skipped in IDLE
    send_byte(8'h52);
    push_frame(8'h52, 8'h05, 8'h00);
    send_byte(8'h05);
    check("rd_ready", bus.cmd_ready, 1'b1);
    check("rd_frame", {bus.cmd, bus.addr, bus.data}, 24'h520500);
    send_byte(8'h0D);
    check("cr_idle_busy", bus.busy, 1'b0);
    check("cr_idle_cmd", bus.cmd, 8'h52);
    send_byte(8'h0A);
    check("lf_idle_busy", bus.busy, 1'b0);

    // Unknown code collected as 3 bytes
    send_byte(8'h99);
    send_byte(8'h02);
    check("unk_not_short", bus.cmd_ready, 1'b0);
    push_frame(8'h99, 8'h02, 8'h11);
    send_byte(8'h11);
    check("unk_frame", {bus.cmd_ready, bus.cmd, bus.addr, bus.data}, 25'h1_990211);

    // CR/LF inside a frame are ordinary bytes
    send_byte(8'h57);
    send_byte(8'h0D);
    push_frame(8'h57, 8'h0D, 8'h0A);
    send_byte(8'h0A);
    check("crlf_in_frame", {bus.cmd_ready, bus.addr, bus.data}, 17'h1_0D0A);

    // Timeout: frame_err exactly TO-1 cycles after the last byte
    send_byte(8'h57);
    send_byte(8'h03);
    push_err();
    for (int k = 1; k <= 15; k++) begin
      wait_cycles(1);
      if (k < 15) check("to_not_yet", bus.frame_err, 1'b0);
      else        check("to_fires", {bus.frame_err, bus.cmd_ready, bus.busy}, 3'b100);
    end
    // Byte on the cycle after the timeout is a new command
    send_byte(8'h52);
    check("to_err_one_cycle", bus.frame_err, 1'b0);
    check("after_to_busy", bus.busy, 1'b1);
    push_frame(8'h52, 8'h01, 8'h00);
    send_byte(8'h01);
    check("after_to_read", {bus.cmd_ready, bus.cmd, bus.addr, bus.data}, 25'h1_520100);

    // Byte coinciding with the timeout edge wins
    send_byte(8'h57);
    send_byte(8'h03);
    wait_cycles(14);
    push_frame(8'h57, 8'h03, 8'h04);
    send_byte(8'h04);
    check("race_no_err", bus.frame_err, 1'b0);
    check("race_ready", {bus.cmd_ready, bus.data}, 9'h1_04);

    // Reset mid-frame discards the partial frame
    send_byte(8'h57);
    send_byte(8'h03);
    rst = 1'b0;
    #1;
    check("rst_async", {bus.busy, bus.cmd_ready, bus.frame_err, bus.cmd}, 11'h000);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(1);
    send_byte(8'h52);
    push_frame(8'h52, 8'h07, 8'h00);
    send_byte(8'h07);
    check("rst_then_read", {bus.cmd_ready, bus.cmd, bus.addr, bus.data}, 25'h1_520700);

    wait_cycles(20);
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
